// File: rtl/cgp_eval_pkg.sv
// Shared types and constants for the CGP truth-table evaluator.
//   state_e    : sweep FSM states
//   cnt_width  : mismatch counter width large enough for a worst-case full sweep
//   DefNIn/DefNOut : default benchmark circuit geometry (8-in / 7-out PLA class)
package cgp_eval_pkg;

  localparam int unsigned DefNIn  = 8;
  localparam int unsigned DefNOut = 7;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Every output bit of every vector can mismatch: 2^n_in * n_out, plus one for zero.
  function automatic int unsigned cnt_width(input int unsigned n_in, input int unsigned n_out);
    return $clog2((2 ** n_in) * n_out + 1);
  endfunction

endpackage

// File: rtl/cgp_truth_table_evaluator_if.sv
// Handshake/data bundle between the fitness controller, the evaluator, the candidate
// netlist and the golden ROM.
//   slave  : evaluator side (drives vec_o and the result signals)
//   master : controller/environment side (drives start/abort/limit and the two responses)
interface cgp_truth_table_evaluator_if
  import cgp_eval_pkg::*;
#(
  parameter int unsigned N_IN  = DefNIn,
  parameter int unsigned N_OUT = DefNOut,
  parameter int unsigned CNT_W = cnt_width(N_IN, N_OUT)
);

  logic             start;
  logic             abort;
  logic [CNT_W-1:0] limit_i;
  logic [N_IN-1:0]  vec_o;
  logic [N_OUT-1:0] dut_po_i;
  logic [N_OUT-1:0] gold_data;
  logic             busy;
  logic             done;
  logic             result_valid;
  logic [CNT_W-1:0] mismatch_cnt;
  logic             perfect;
  logic             over_limit;

  modport slave (
    input  start, abort, limit_i, dut_po_i, gold_data,
    output vec_o, busy, done, result_valid, mismatch_cnt, perfect, over_limit
  );

  modport master (
    output start, abort, limit_i, dut_po_i, gold_data,
    input  vec_o, busy, done, result_valid, mismatch_cnt, perfect, over_limit
  );

endinterface

// File: rtl/cgp_popcount.sv
// Combinational population count.
//   bits_i  : W-bit input vector
//   count_o : number of set bits in bits_i
module cgp_popcount #(
  parameter int unsigned W  = 7,
  parameter int unsigned CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  bits_i,
  output logic [CW-1:0] count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < W; i++) begin
      count_o = count_o + CW'(bits_i[i]);
    end
  end

endmodule

// File: rtl/cgp_truth_table_evaluator.sv
// Sweeps all 2^N_IN input vectors into a candidate circuit, compares each response with a
// golden ROM word and accumulates the Hamming distance, with optional early exit.
//   clk, rst : clock (rising edge) and asynchronous active-high reset
//   bus      : slave modport; start/abort/limit_i/dut_po_i/gold_data in, vector and results out
module cgp_truth_table_evaluator
  import cgp_eval_pkg::*;
#(
  parameter int unsigned N_IN   = DefNIn,
  parameter int unsigned N_OUT  = DefNOut,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned CNT_W  = cnt_width(N_IN, N_OUT)
) (
  input logic                        clk,
  input logic                        rst,
  cgp_truth_table_evaluator_if.slave bus
);

  localparam int unsigned SlotW = $clog2(SETTLE + 1);
  localparam int unsigned PcW   = $clog2(N_OUT + 1);

  state_e           state_q, state_d;
  logic [SlotW-1:0] slot_q, slot_d;
  logic [N_IN-1:0]  vec_q, vec_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             perfect_q, perfect_d;
  logic             over_q, over_d;

  logic [PcW-1:0]   pc;
  logic [CNT_W-1:0] acc_new;
  logic             last_vec;
  logic             exceed;

  cgp_popcount #(
    .W (N_OUT),
    .CW(PcW)
  ) u_popcount (
    .bits_i (bus.dut_po_i ^ bus.gold_data),
    .count_o(pc)
  );

  assign acc_new  = acc_q + CNT_W'(pc);
  assign last_vec = &vec_q;
  assign exceed   = acc_new > bus.limit_i;

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    vec_d     = vec_q;
    acc_d     = acc_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    valid_d   = valid_q;
    cnt_d     = cnt_q;
    perfect_d = perfect_q;
    over_d    = over_q;
    case (state_q)
      StIdle: begin
        if (bus.start && !bus.abort) begin
          state_d   = StRun;
          slot_d    = '0;
          vec_d     = '0;
          acc_d     = '0;
          busy_d    = 1'b1;
          valid_d   = 1'b0;
          cnt_d     = '0;
          perfect_d = 1'b0;
          over_d    = 1'b0;
        end
      end
      StRun: begin
        if (bus.abort) begin
          // vec_o is deliberately left where it was
          state_d = StIdle;
          busy_d  = 1'b0;
        end else if (slot_q == SlotW'(SETTLE)) begin
          // ROM word for vec_q has been valid since the previous edge
          acc_d  = acc_new;
          slot_d = '0;
          if (last_vec || exceed) begin
            state_d   = StDone;
            cnt_d     = acc_new;
            over_d    = exceed;
            perfect_d = (acc_new == '0) && last_vec && !exceed;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            valid_d   = 1'b1;
          end else begin
            vec_d = vec_q + 1'b1;
          end
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      slot_q    <= '0;
      vec_q     <= '0;
      acc_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
      perfect_q <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      vec_q     <= vec_d;
      acc_q     <= acc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
      perfect_q <= perfect_d;
      over_q    <= over_d;
    end
  end

  assign bus.vec_o        = vec_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.result_valid = valid_q;
  assign bus.mismatch_cnt = cnt_q;
  assign bus.perfect      = perfect_q;
  assign bus.over_limit   = over_q;

endmodule
